hall_input_filter: RTL and testbench
====================================

HALL_INPUT_FILTER -- requirements
Module: hall_input_filter

Interface
REQ-001 Parameter FILTER_CYCLES, default 16, SHALL set the stability count in clocks; legal range 1..255.
REQ-002 Parameter PERIOD_WIDTH, default 16, SHALL set the width of the period counter and the period output.
REQ-003 Port clock  input  1  SHALL be the single rising-edge system clock.
REQ-004 Port reset_n  input  1  SHALL be the reset: asynchronous assert, active low.
REQ-005 Port hall_raw  input  3  SHALL carry the unsynchronised hall pins; bit 2 = hall 1, bit 0 = hall 3.
REQ-006 Port hall  output  3  SHALL carry the filtered hall state feeding the commutation stage.
REQ-007 Port step  output  1  SHALL pulse for one clock when hall changes.
REQ-008 Port dir_obs  output  1  SHALL indicate the last step direction: 1 = forward, 0 = reverse.
REQ-009 Port period  output  PERIOD_WIDTH  SHALL carry the clock count between the last two steps.
REQ-010 Port period_valid  output  1  SHALL be high while period is meaningful.
REQ-011 Port stall  output  1  SHALL be high while the period counter is saturated.
REQ-012 Port hall_fault  output  1  SHALL be high while hall is 000 or 111.
REQ-013 Port invalid_seq  output  1  SHALL pulse for one clock on an illegal transition.

Function
REQ-014 hall_raw SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 Candidate/count logic:
- Synchroniser output differs from candidate: candidate <= synchroniser output, count <= 0.
- Otherwise: count increments, saturating at FILTER_CYCLES-1.
REQ-016 When count = FILTER_CYCLES-1 and candidate != hall, hall SHALL load candidate and step SHALL pulse in that same cycle.
REQ-017 A raw change held stable SHALL appear on hall at the (FILTER_CYCLES+3)th rising edge after the change; any raw pulse shorter than FILTER_CYCLES clocks SHALL never reach hall.
REQ-018 The forward sequence SHALL be 101->100->110->010->011->001->101; reverse is the opposite order.
REQ-019 FSM states SHALL be UNLOCKED, LOCKED and FAULT.
REQ-020 State transitions:
- UNLOCKED -> LOCKED on the first step to a valid state.
- Any state -> FAULT on a step to 000 or 111.
- FAULT -> LOCKED on a step to a valid state.
REQ-021 A step between two valid states SHALL set dir_obs from the sequence; dir_obs SHALL hold otherwise.
REQ-022 Period counter behaviour:
- Increments every clock, saturating at all-ones; stall = (counter = all-ones).
- On step: period <= counter+1 (saturating) and counter <= 0.
REQ-023 period_valid SHALL set on a LOCKED-to-valid step in the same direction as the previous step.
REQ-024 period_valid SHALL clear on any of: stall, entry to FAULT, direction reversal, invalid_seq.
REQ-025 Simultaneous step and counter saturation SHALL resolve in favour of step (counter <= 0, stall = 0 next cycle).
REQ-026 hall_fault SHALL equal (hall = 000 or hall = 111), registered with hall.

Reset
REQ-027 Reset SHALL force the following:
- Synchroniser, candidate and hall to 000; count to 0.
- FSM to UNLOCKED; period counter to 0; period to 0.
- step, dir_obs, period_valid, stall and invalid_seq to 0; hall_fault to 1.
REQ-028 Reset mid-filter SHALL discard the pending candidate; after release, filtering SHALL restart from the REQ-017 latency.

Configuration
REQ-029 With HALL_SEQ_CHECK_EN defined, a step between two valid non-adjacent states SHALL pulse invalid_seq, clear period_valid and leave dir_obs unchanged.
REQ-030 Without HALL_SEQ_CHECK_EN, invalid_seq SHALL be tied 0 and any valid-to-valid step SHALL set dir_obs = 1 when the new state is the forward successor, else 0.

Verification
REQ-031 FILTER_CYCLES=16; hall_raw 000->101 held -> hall = 101 and step pulses at edge 19; state LOCKED; hall_fault falls with hall.
REQ-032 hall_raw 101 glitches to 100 for 15 clocks, then returns -> hall stays 101 and step never pulses.
REQ-033 Forward sequence with 1000 clocks per state -> dir_obs = 1; period = 1000; period_valid = 1 from the second step; reversal -> dir_obs = 0 and period_valid = 0 until the next same-direction step.
REQ-034 PERIOD_WIDTH=8; hall held 300 clocks -> stall = 1 and period_valid = 0; next step -> period = 255 and stall = 0.
REQ-035 HALL_SEQ_CHECK_EN defined; 101->010 -> invalid_seq pulses once and period_valid = 0; hall_raw 111 -> hall_fault = 1 and state FAULT.
REQ-036 reset_n asserted while a candidate is at count 10 -> all outputs at reset values immediately, asynchronously; after release, full REQ-017 latency is required.

Source files
------------

// File: rtl/hall_input_filter.sv
// rtl/hall_input_filter.sv - hall sensor synchroniser, glitch filter, sequence decoder and period meter
//
// Ports:
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   hall_raw[2:0] in   unsynchronised hall pins (bit 2 = hall 1, bit 0 = hall 3)
//   hall[2:0]     out  filtered hall state
//   step          out  one-clock pulse when hall changes
//   dir_obs       out  last step direction, 1 = forward, 0 = reverse
//   period        out  clocks between the last two steps (saturating)
//   period_valid  out  period reflects steady same-direction motion
//   stall         out  period counter saturated
//   hall_fault    out  hall is 000 or 111
//   invalid_seq   out  one-clock pulse on a step between non-adjacent valid states
//
// Build option: HALL_SEQ_CHECK_EN enables adjacency checking of valid-to-valid steps.

module hall_input_filter #(
  parameter int FILTER_CYCLES = 16,
  parameter int PERIOD_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [2:0]              hall_raw,
  output logic [2:0]              hall,
  output logic                    step,
  output logic                    dir_obs,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stall,
  output logic                    hall_fault,
  output logic                    invalid_seq
);

  localparam logic [7:0]              CNT_MAX = 8'(FILTER_CYCLES - 1);
  localparam logic [7:0]              CNT_ONE = 8'd1;
  localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;
  localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_LOCKED,
    ST_FAULT
  } state_t;

  // Forward rotation: 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101.
  function automatic logic [2:0] fwd_next(input logic [2:0] x);
    logic [2:0] r;
    case (x)
      3'b101:  r = 3'b100;
      3'b100:  r = 3'b110;
      3'b110:  r = 3'b010;
      3'b010:  r = 3'b011;
      3'b011:  r = 3'b001;
      3'b001:  r = 3'b101;
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic is_valid(input logic [2:0] x);
    return (x != 3'b000) && (x != 3'b111);
  endfunction

  logic [2:0]              sync1_q, sync1_d;
  logic [2:0]              sync2_q, sync2_d;
  logic [2:0]              cand_q, cand_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              hall_q, hall_d;
  logic                    step_q, step_d;
  logic                    dir_q, dir_d;
  logic                    dir_known_q, dir_known_d;
  logic [PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    pv_q, pv_d;
  logic                    fault_q, fault_d;
  logic                    inv_q, inv_d;
  state_t                  state_q, state_d;

  logic load;
  logic old_ok;
  logic new_ok;
  logic fwd_match;
  logic dir_step;
  logic new_dir;
  logic stall_now;
  logic reversal;
  logic enter_fault;

  // Filter, step and direction decode.
  always_comb begin
    sync1_d = hall_raw;
    sync2_d = sync1_q;

    // Candidate restarts its stability count whenever the synchronised input moves.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 8'd0;
    end else begin
      cand_d = cand_q;
      cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    load    = (cnt_q == CNT_MAX) && (cand_q != hall_q);
    hall_d  = load ? cand_q : hall_q;
    step_d  = load;
    fault_d = !is_valid(hall_d);

    old_ok    = is_valid(hall_q);
    new_ok    = is_valid(cand_q);
    fwd_match = (cand_q == fwd_next(hall_q));
    new_dir   = fwd_match;

`ifdef HALL_SEQ_CHECK_EN
    // Only adjacent moves carry a direction; anything else is flagged and ignored.
    dir_step = load && old_ok && new_ok &&
               (fwd_match || (hall_q == fwd_next(cand_q)));
    inv_d    = load && old_ok && new_ok &&
               !(fwd_match || (hall_q == fwd_next(cand_q)));
`else
    dir_step = load && old_ok && new_ok;
    inv_d    = 1'b0;
`endif

    dir_d       = dir_step ? new_dir : dir_q;
    // Direction is "known" only if the most recent step itself had a direction,
    // so a step out of FAULT never counts as the first half of a same-direction pair.
    dir_known_d = load ? dir_step : dir_known_q;
  end

  // Period measurement; a step always wins over saturation.
  always_comb begin
    stall_now = (per_cnt_q == PER_MAX);
    if (load) begin
      per_cnt_d = '0;
      period_d  = stall_now ? PER_MAX : per_cnt_q + PER_ONE;
    end else begin
      per_cnt_d = stall_now ? per_cnt_q : per_cnt_q + PER_ONE;
      period_d  = period_q;
    end
  end

  // Lock state machine.
  always_comb begin
    state_d = state_q;
    if (load) begin
      case (state_q)
        ST_UNLOCKED: state_d = new_ok ? ST_LOCKED : ST_FAULT;
        ST_LOCKED:   state_d = new_ok ? ST_LOCKED : ST_FAULT;
        ST_FAULT:    state_d = new_ok ? ST_LOCKED : ST_FAULT;
        default:     state_d = ST_UNLOCKED;
      endcase
    end
  end

  // Period validity qualification.
  always_comb begin
    enter_fault = load && !new_ok;
    reversal    = dir_step && dir_known_q && (new_dir != dir_q);
    pv_d        = pv_q;
    if (stall_now) begin
      pv_d = 1'b0;
    end
    if (load) begin
      if (enter_fault || reversal || inv_d) begin
        pv_d = 1'b0;
      end else if ((state_q == ST_LOCKED) && dir_step && dir_known_q &&
                   (new_dir == dir_q) && !stall_now) begin
        pv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      cand_q      <= 3'b000;
      cnt_q       <= 8'd0;
      hall_q      <= 3'b000;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      dir_known_q <= 1'b0;
      per_cnt_q   <= '0;
      period_q    <= '0;
      pv_q        <= 1'b0;
      fault_q     <= 1'b1;
      inv_q       <= 1'b0;
      state_q     <= ST_UNLOCKED;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      hall_q      <= hall_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      dir_known_q <= dir_known_d;
      per_cnt_q   <= per_cnt_d;
      period_q    <= period_d;
      pv_q        <= pv_d;
      fault_q     <= fault_d;
      inv_q       <= inv_d;
      state_q     <= state_d;
    end
  end

  assign hall         = hall_q;
  assign step         = step_q;
  assign dir_obs      = dir_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign stall        = (per_cnt_q == PER_MAX);
  assign hall_fault   = fault_q;
  assign invalid_seq  = inv_q;

endmodule

// File: tb/tb_hall_input_filter.sv
// tb/tb_hall_input_filter.sv - self-checking bench for hall_input_filter

module tb_hall_input_filter;

  localparam int F    = 16;
  localparam int PMAX = 65535;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  hall_raw = 3'b000;
  logic [2:0]  hall_raw_b = 3'b000;

  logic [2:0]  hall, hall_b;
  logic        step, step_b, dir_obs, dir_obs_b;
  logic [15:0] period;
  logic [7:0]  period_b;
  logic        period_valid, period_valid_b, stall, stall_b;
  logic        hall_fault, hall_fault_b, invalid_seq, invalid_seq_b;

  hall_input_filter #(.FILTER_CYCLES(F), .PERIOD_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .hall_raw(hall_raw), .hall(hall), .step(step),
    .dir_obs(dir_obs), .period(period), .period_valid(period_valid), .stall(stall),
    .hall_fault(hall_fault), .invalid_seq(invalid_seq));

  hall_input_filter #(.FILTER_CYCLES(F), .PERIOD_WIDTH(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .hall_raw(hall_raw_b), .hall(hall_b), .step(step_b),
    .dir_obs(dir_obs_b), .period(period_b), .period_valid(period_valid_b), .stall(stall_b),
    .hall_fault(hall_fault_b), .invalid_seq(invalid_seq_b));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw sample history plus plain step/direction rules.
  logic [2:0] hist[$];
  logic [2:0] m_hall;
  bit         m_step, m_dir, m_dirk, m_pv, m_inv;
  int         m_cnt, m_period, m_state;   // m_state: 0 unlocked, 1 locked, 2 fault
  int         seq_tab[6] = '{5, 4, 6, 2, 3, 1};

  logic [24:0] act;
  assign act = {hall, step, dir_obs, period_valid, stall, hall_fault, invalid_seq, period};

  function automatic int pos(input logic [2:0] x);
    for (int i = 0; i < 6; i++) if (seq_tab[i] == int'(x)) return i;
    return -1;
  endfunction

  function automatic logic [2:0] fwd_of(input logic [2:0] x);
    int p = pos(x);
    return (p < 0) ? 3'b101 : 3'(seq_tab[(p + 1) % 6]);
  endfunction

  function automatic logic [2:0] rev_of(input logic [2:0] x);
    int p = pos(x);
    return (p < 0) ? 3'b101 : 3'(seq_tab[(p + 5) % 6]);
  endfunction

  function automatic logic [2:0] samp(input int k);
    return (k < hist.size()) ? hist[k] : 3'b000;
  endfunction

  function automatic logic [24:0] exp_vec();
    return {m_hall, m_step, m_dir, m_pv, (m_cnt == PMAX),
            (m_hall == 3'b000 || m_hall == 3'b111), m_inv, 16'(m_period)};
  endfunction

  task automatic model_reset();
    hist.delete();
    m_hall = 3'b000; m_step = 0; m_dir = 0; m_dirk = 0; m_pv = 0; m_inv = 0;
    m_cnt = 0; m_period = 0; m_state = 0;
  endtask

  task automatic model_edge();
    logic [2:0] c;
    bit load, stall_now, pv, dirstep, nd, inv, rev;
    int po, pn, d;
    hist.push_front(hall_raw);
    if (hist.size() > F + 4) void'(hist.pop_back());
    // Hall takes a value once it has sat, after 2 sync + 1 candidate stage, for F samples.
    c = samp(3);
    load = (c != m_hall);
    for (int k = 3; k <= F + 2; k++) if (samp(k) != c) load = 0;
    stall_now = (m_cnt == PMAX);
    pv = m_pv;
    if (stall_now) pv = 0;
    m_step = load;
    m_inv  = 0;
    if (load) begin
      po = pos(m_hall); pn = pos(c);
      dirstep = 0; nd = 0; inv = 0;
      if (po >= 0 && pn >= 0) begin
        d = (pn - po + 6) % 6;
`ifdef HALL_SEQ_CHECK_EN
        if (d == 1) begin dirstep = 1; nd = 1; end
        else if (d == 5) begin dirstep = 1; nd = 0; end
        else inv = 1;
`else
        dirstep = 1;
        nd = (d == 1);
`endif
      end
      rev = dirstep && m_dirk && (nd != m_dir);
      if (pn < 0 || rev || inv) pv = 0;
      else if (m_state == 1 && dirstep && m_dirk && nd == m_dir && !stall_now) pv = 1;
      m_period = (m_cnt + 1 > PMAX) ? PMAX : m_cnt + 1;
      m_cnt = 0;
      if (dirstep) m_dir = nd;
      m_dirk = dirstep;
      m_inv = inv;
      m_hall = c;
      m_state = (pn < 0) ? 2 : 1;
    end else begin
      m_cnt = (m_cnt + 1 > PMAX) ? PMAX : m_cnt + 1;
    end
    m_pv = pv;
  endtask

  // One rising edge with the model stepped alongside; returns at the falling edge.
  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    model_reset();
    n_checks++;
    if (act !== 25'b000_0_0_0_0_1_0_0000000000000000) begin
      n_fail++; $display("FAIL reset_a act=%h exp=%h", act, 25'b000_0_0_0_0_1_0_0000000000000000);
    end
    n_checks++;
    if ({hall_b, step_b, stall_b, hall_fault_b, period_b, period_valid_b, invalid_seq_b} !== 16'b000_0_0_1_00000000_0_0) begin
      n_fail++; $display("FAIL reset_b act=%b", {hall_b, step_b, stall_b, hall_fault_b, period_b, period_valid_b, invalid_seq_b});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_filter_latency();
    hall_raw = 3'b101;
    for (int e = 1; e <= 25; e++) begin
      tick();
      n_checks++;
      if ({hall, step, hall_fault} !== {(e >= 19) ? 3'b101 : 3'b000, e == 19, e < 19}) begin
        n_fail++; $display("FAIL latency edge=%0d act=%b exp=%b", e, {hall, step, hall_fault},
                           {(e >= 19) ? 3'b101 : 3'b000, e == 19, e < 19});
      end
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL latency_model edge=%0d act=%h exp=%h", e, act, exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    hall_raw = 3'b100;
    for (int e = 1; e <= 40; e++) begin
      if (e == 16) hall_raw = 3'b101;
      tick();
      n_checks++;
      if ({hall, step} !== {3'b101, 1'b0} || act !== exp_vec()) begin
        n_fail++; $display("FAIL glitch edge=%0d act=%h exp=%h", e, act, exp_vec());
      end
    end
  endtask

  task automatic test_forward_period();
    logic [2:0] cur = 3'b101;
    for (int s = 0; s < 10; s++) begin
      cur = (s < 8) ? fwd_of(cur) : rev_of(cur);
      hall_raw = cur;
      for (int i = 0; i < 1000; i++) begin
        tick();
        n_checks++;
        if (act !== exp_vec()) begin
          n_fail++; $display("FAIL fwd_model seg=%0d i=%0d act=%h exp=%h", s, i, act, exp_vec());
        end
        if (i == 18) begin
          n_checks++;
          if (s == 0 && {step, dir_obs, period_valid} !== 3'b110) begin
            n_fail++; $display("FAIL fwd_first act=%b exp=110", {step, dir_obs, period_valid});
          end else if (s >= 1 && s < 8 && {step, dir_obs, period_valid, period} !== {3'b111, 16'd1000}) begin
            n_fail++; $display("FAIL fwd_step seg=%0d act=%b/%0d exp=111/1000", s, {step, dir_obs, period_valid}, period);
          end else if (s == 8 && {step, dir_obs, period_valid} !== 3'b100) begin
            n_fail++; $display("FAIL reversal act=%b exp=100", {step, dir_obs, period_valid});
          end else if (s == 9 && {step, dir_obs, period_valid, period} !== {3'b101, 16'd1000}) begin
            n_fail++; $display("FAIL rev_second act=%b/%0d exp=101/1000", {step, dir_obs, period_valid}, period);
          end
        end
      end
    end
  endtask

  task automatic test_fault();
    logic [2:0] vals[2] = '{3'b111, 3'b101};
    for (int s = 0; s < 2; s++) begin
      hall_raw = vals[s];
      for (int i = 0; i < 40; i++) begin
        tick();
        n_checks++;
        if (act !== exp_vec()) begin
          n_fail++; $display("FAIL fault_model seg=%0d i=%0d act=%h exp=%h", s, i, act, exp_vec());
        end
      end
      n_checks++;
      if ({hall, hall_fault, period_valid} !== {vals[s], s == 0, 1'b0}) begin
        n_fail++; $display("FAIL fault seg=%0d act=%b exp=%b", s, {hall, hall_fault, period_valid}, {vals[s], s == 0, 1'b0});
      end
    end
  endtask

  task automatic test_seq_check();
    logic [2:0] vals[6] = '{3'b001, 3'b011, 3'b001, 3'b101, 3'b010, 3'b111};
    for (int s = 0; s < 6; s++) begin
      hall_raw = vals[s];
      for (int i = 0; i < 100; i++) begin
        tick();
        n_checks++;
        if (act !== exp_vec()) begin
          n_fail++; $display("FAIL seq_model seg=%0d i=%0d act=%h exp=%h", s, i, act, exp_vec());
        end
        if (i == 18 && s == 3) begin
          n_checks++;
          if ({period_valid, dir_obs, period} !== {2'b11, 16'd100}) begin
            n_fail++; $display("FAIL seq_pv act=%b/%0d exp=11/100", {period_valid, dir_obs}, period);
          end
        end
        if (i == 18 && s == 4) begin
          n_checks++;
`ifdef HALL_SEQ_CHECK_EN
          if ({step, invalid_seq, period_valid, dir_obs} !== 4'b1101) begin
            n_fail++; $display("FAIL seq_jump act=%b exp=1101", {step, invalid_seq, period_valid, dir_obs});
          end
`else
          if ({step, invalid_seq, period_valid, dir_obs} !== 4'b1000) begin
            n_fail++; $display("FAIL seq_jump act=%b exp=1000", {step, invalid_seq, period_valid, dir_obs});
          end
`endif
        end
      end
    end
    n_checks++;
    if ({hall, hall_fault, invalid_seq} !== 5'b111_1_0) begin
      n_fail++; $display("FAIL seq_fault act=%b exp=11110", {hall, hall_fault, invalid_seq});
    end
  endtask

  task automatic test_async_reset();
    hall_raw = 3'b101;
    repeat (13) tick();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (act !== 25'b000_0_0_0_0_1_0_0000000000000000) begin
      n_fail++; $display("FAIL async_reset act=%h exp=%h", act, 25'b000_0_0_0_0_1_0_0000000000000000);
    end
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      tick();
      n_checks++;
      if ({hall, step} !== {(e >= 19) ? 3'b101 : 3'b000, e == 19} || act !== exp_vec()) begin
        n_fail++; $display("FAIL reset_relatch edge=%0d act=%h exp=%h", e, act, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] cur = hall_raw;
    int run = 0;
    int r;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4)       cur = fwd_of(cur);
        else if (r < 7)  cur = rev_of(cur);
        else if (r == 7) cur = 3'($urandom_range(0, 7));
        hall_raw = cur;
        run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, F) : $urandom_range(F, 60);
      end
      run--;
      tick();
      n_checks++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL random c=%0d act=%h exp=%h", c, act, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    hall_raw_b = 3'b101;
    repeat (330) tick();
    n_checks++;
    if ({hall_b, stall_b, period_valid_b} !== 5'b101_1_0) begin
      n_fail++; $display("FAIL stall_set act=%b exp=10110", {hall_b, stall_b, period_valid_b});
    end
    hall_raw_b = 3'b100;
    repeat (18) tick();
    n_checks++;
    if ({step_b, stall_b} !== 2'b01) begin
      n_fail++; $display("FAIL stall_hold act=%b exp=01", {step_b, stall_b});
    end
    tick();
    n_checks++;
    if ({hall_b, step_b, stall_b, period_b} !== {3'b100, 2'b10, 8'd255}) begin
      n_fail++; $display("FAIL stall_step act=%b/%0d exp=10010/255", {hall_b, step_b, stall_b}, period_b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_filter_latency();
    test_glitch();
    test_forward_period();
    test_fault();
    test_seq_check();
    test_async_reset();
    test_random();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
